// File: rtl/sequential_divider_if.sv
// Start/ready handshake bundle shared by the iterative divider and its control harness.
// master drives the request and operands; slave returns status and results.
interface sequential_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, ready, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, ready, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/sequential_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock, one division in flight.
// Define DIVIDER_SIGNED_EN for two's-complement operands (magnitudes divided, signs fixed up).
module sequential_divider #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sequential_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH:0]   rem_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic             busy_reg;
    logic             ready_reg;
    logic             dbz_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;

    logic [WIDTH:0]   shift_next;
    logic [WIDTH:0]   diff_next;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] q_next;
    logic             fits_next;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] quotient_final;
    logic [WIDTH-1:0] remainder_final;

`ifdef DIVIDER_SIGNED_EN
    logic dividend_neg;
    logic divisor_neg;
    logic neg_q_reg;
    logic neg_r_reg;

    // The most-negative value has magnitude 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        dividend_neg    = bus.dividend[WIDTH-1];
        divisor_neg     = bus.divisor[WIDTH-1];
        dividend_mag    = dividend_neg ? -bus.dividend : bus.dividend;
        divisor_mag     = divisor_neg  ? -bus.divisor  : bus.divisor;
        quotient_final  = neg_q_reg ? -q_next : q_next;
        remainder_final = neg_r_reg ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
    end
`else
    always_comb begin
        dividend_mag    = bus.dividend;
        divisor_mag     = bus.divisor;
        quotient_final  = q_next;
        remainder_final = rem_next[WIDTH-1:0];
    end
`endif

    // A set bit shifted out of the partial remainder means it already exceeds the divisor.
    always_comb begin
        shift_next = {rem_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        diff_next  = shift_next - {1'b0, divisor_reg};
        fits_next  = rem_reg[WIDTH] | ~diff_next[WIDTH];
        rem_next   = fits_next ? diff_next : shift_next;
        q_next     = {q_reg[WIDTH-2:0], fits_next};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            rem_reg       <= '0;
            q_reg         <= '0;
            divisor_reg   <= '0;
            busy_reg      <= 1'b0;
            ready_reg     <= 1'b0;
            dbz_reg       <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
`ifdef DIVIDER_SIGNED_EN
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
`endif
        end else begin
            ready_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
                        rem_reg       <= '0;
                        q_reg         <= dividend_mag;
                        divisor_reg   <= divisor_mag;
                        cnt_reg       <= CW'(WIDTH);
`ifdef DIVIDER_SIGNED_EN
                        neg_q_reg     <= dividend_neg ^ divisor_neg;
                        neg_r_reg     <= dividend_neg;
`endif
                        if (bus.divisor == '0) begin
                            // No iterations needed: results are defined directly.
                            state_reg     <= DONE;
                            busy_reg      <= 1'b0;
                            ready_reg     <= 1'b1;
                            dbz_reg       <= 1'b1;
                            quotient_reg  <= '1;
                            remainder_reg <= bus.dividend;
                        end else begin
                            state_reg     <= RUN;
                            busy_reg      <= 1'b1;
                            dbz_reg       <= 1'b0;
                            quotient_reg  <= '0;
                            remainder_reg <= '0;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    rem_reg <= rem_next;
                    q_reg   <= q_next;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CW'(1)) begin
                        state_reg     <= DONE;
                        busy_reg      <= 1'b0;
                        ready_reg     <= 1'b1;
                        quotient_reg  <= quotient_final;
                        remainder_reg <= remainder_final;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.ready       = ready_reg;
    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider: expected results queued at each accepted start,
// popped and compared when ready pulses. Build with DIVIDER_SIGNED_EN for the signed variant.
module tb_sequential_divider;
    localparam int WIDTH = 4;
    localparam int BOUND = 40;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sequential_divider_if #(.WIDTH(WIDTH)) bus ();

    sequential_divider #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.dbz = 1'b0;
`ifdef DIVIDER_SIGNED_EN
            if (a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1) begin
                e.q = a;
                e.r = '0;
            end else begin
                e.q = $signed(a) / $signed(b);
                e.r = $signed(a) % $signed(b);
            end
`else
            e.q = a / b;
            e.r = a % b;
`endif
        end
        return e;
    endfunction

    // Pulse start for one cycle; afterwards scramble operands to show they are not re-sampled.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = WIDTH'($urandom);
        bus.divisor  = WIDTH'($urandom);
    endtask

    task automatic wait_ready(output bit seen, output int cyc);
        cyc = 0;
        while (!bus.ready && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        seen = bus.ready;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.dividend = 4'd11;
        bus.divisor  = 4'd3;
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.ready, bus.div_by_zero, bus.quotient, bus.remainder} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%0b ready=%0b dbz=%0b q=%0d r=%0d, required all 0",
                     bus.busy, bus.ready, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_no_start: busy=%0b ready=%0b, required 0 0", bus.busy, bus.ready);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        int   cyc;
        int   busy_cnt;
        sb.push_back(model(4'd11, 4'd3));
        issue(4'd11, 4'd3);
        cyc      = 0;
        busy_cnt = 0;
        while (!bus.ready && cyc < BOUND) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (busy_cnt != WIDTH) begin
            n_bad++;
            $display("FAIL basic_busy_cycles: got %0d, required %0d", busy_cnt, WIDTH);
        end
        n_cmp++;
        if (!bus.ready || cyc != WIDTH) begin
            n_bad++;
            $display("FAIL basic_latency: ready=%0b after %0d cycles, required ready=1 after %0d",
                     bus.ready, cyc, WIDTH);
        end else begin
            e = sb.pop_front();
            $display("txn %0d/%0d -> q=%0d r=%0d dbz=%0b", e.a, e.b,
                     bus.quotient, bus.remainder, bus.div_by_zero);
            n_cmp++;
            if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dbz}) begin
                n_bad++;
                $display("FAIL basic_result: q=%0d r=%0d dbz=%0b, required q=%0d r=%0d dbz=%0b",
                         bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
            end
            @(negedge clk);
            n_cmp++;
            if (bus.ready !== 1'b0 || bus.busy !== 1'b0 ||
                {bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dbz}) begin
                n_bad++;
                $display("FAIL basic_hold: ready=%0b busy=%0b q=%0d r=%0d, required 0 0 q=%0d r=%0d",
                         bus.ready, bus.busy, bus.quotient, bus.remainder, e.q, e.r);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   seen;
        int   cyc;
        sb.push_back(model(4'd15, 4'd1));
        issue(4'd15, 4'd1);
        wait_ready(seen, cyc);
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL b2b_first_ready: ready=0 after %0d cycles, required 1", cyc);
        end else begin
            e = sb.pop_front();
            $display("txn %0d/%0d -> q=%0d r=%0d dbz=%0b", e.a, e.b,
                     bus.quotient, bus.remainder, bus.div_by_zero);
            n_cmp++;
            if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dbz}) begin
                n_bad++;
                $display("FAIL b2b_first: q=%0d r=%0d dbz=%0b, required q=%0d r=%0d dbz=%0b",
                         bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
            end
        end
        // Start presented during the DONE cycle.
        bus.start    = 1'b1;
        bus.dividend = 4'd6;
        bus.divisor  = 4'd7;
        sb.push_back(model(4'd6, 4'd7));
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.ready !== 1'b0 || bus.quotient !== '0 || bus.remainder !== '0) begin
            n_bad++;
            $display("FAIL b2b_no_gap: busy=%0b ready=%0b q=%0d r=%0d, required 1 0 0 0",
                     bus.busy, bus.ready, bus.quotient, bus.remainder);
        end
        wait_ready(seen, cyc);
        n_cmp++;
        if (!seen || cyc != WIDTH) begin
            n_bad++;
            $display("FAIL b2b_second_latency: ready=%0b after %0d cycles, required 1 after %0d",
                     seen, cyc, WIDTH);
        end else begin
            e = sb.pop_front();
            $display("txn %0d/%0d -> q=%0d r=%0d dbz=%0b", e.a, e.b,
                     bus.quotient, bus.remainder, bus.div_by_zero);
            n_cmp++;
            if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dbz}) begin
                n_bad++;
                $display("FAIL b2b_second: q=%0d r=%0d dbz=%0b, required q=%0d r=%0d dbz=%0b",
                         bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
            end
        end
    endtask

    task automatic test_div_by_zero();
        exp_t e;
        bit   seen;
        int   cyc;
        sb.push_back(model(4'd7, 4'd0));
        issue(4'd7, 4'd0);
        n_cmp++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL dbz_latency: ready=%0b busy=%0b one edge after accept, required 1 0",
                     bus.ready, bus.busy);
        end else begin
            e = sb.pop_front();
            $display("txn %0d/%0d -> q=%0d r=%0d dbz=%0b", e.a, e.b,
                     bus.quotient, bus.remainder, bus.div_by_zero);
            n_cmp++;
            if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dbz}) begin
                n_bad++;
                $display("FAIL dbz_result: q=%0d r=%0d dbz=%0b, required q=%0d r=%0d dbz=%0b",
                         bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
            end
            repeat (3) @(negedge clk);
            n_cmp++;
            if (bus.ready !== 1'b0 ||
                {bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dbz}) begin
                n_bad++;
                $display("FAIL dbz_hold_idle: ready=%0b q=%0d r=%0d dbz=%0b, required 0 q=%0d r=%0d dbz=%0b",
                         bus.ready, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
            end
        end
        sb.push_back(model(4'd9, 4'd4));
        issue(4'd9, 4'd4);
        n_cmp++;
        if (bus.div_by_zero !== 1'b0 || bus.quotient !== '0 || bus.remainder !== '0) begin
            n_bad++;
            $display("FAIL dbz_clear_on_accept: dbz=%0b q=%0d r=%0d, required 0 0 0",
                     bus.div_by_zero, bus.quotient, bus.remainder);
        end
        wait_ready(seen, cyc);
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL dbz_next_ready: ready=0 after %0d cycles, required 1", cyc);
        end else begin
            e = sb.pop_front();
            $display("txn %0d/%0d -> q=%0d r=%0d dbz=%0b", e.a, e.b,
                     bus.quotient, bus.remainder, bus.div_by_zero);
            n_cmp++;
            if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dbz}) begin
                n_bad++;
                $display("FAIL dbz_next_result: q=%0d r=%0d dbz=%0b, required q=%0d r=%0d dbz=%0b",
                         bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
            end
        end
    endtask

    task automatic test_start_while_busy();
        exp_t e;
        bit   seen;
        int   cyc;
        int   extra;
        sb.push_back(model(4'd13, 4'd2));
        issue(4'd13, 4'd2);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 4'd1;
        bus.divisor  = 4'd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_ready(seen, cyc);
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL busy_ignore_ready: ready=0 after %0d cycles, required 1", cyc);
        end else begin
            e = sb.pop_front();
            $display("txn %0d/%0d -> q=%0d r=%0d dbz=%0b", e.a, e.b,
                     bus.quotient, bus.remainder, bus.div_by_zero);
            n_cmp++;
            if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dbz}) begin
                n_bad++;
                $display("FAIL busy_ignore_result: q=%0d r=%0d dbz=%0b, required q=%0d r=%0d dbz=%0b",
                         bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
            end
        end
        extra = 0;
        repeat (WIDTH + 3) begin
            @(negedge clk);
            if (bus.ready || bus.busy) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_bad++;
            $display("FAIL busy_ignore_single: %0d extra busy/ready cycles, required 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        bit   seen;
        int   cyc;
        int   extra;
        sb.push_back(model(4'd13, 4'd2));
        issue(4'd13, 4'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        n_cmp++;
        if ({bus.busy, bus.ready, bus.div_by_zero, bus.quotient, bus.remainder} !== '0) begin
            n_bad++;
            $display("FAIL abort_state: busy=%0b ready=%0b dbz=%0b q=%0d r=%0d, required all 0",
                     bus.busy, bus.ready, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        extra = 0;
        repeat (WIDTH + 3) begin
            @(negedge clk);
            if (bus.ready || bus.busy) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_bad++;
            $display("FAIL abort_no_ready: %0d busy/ready cycles after abort, required 0", extra);
        end
        sb.push_back(model(4'd8, 4'd3));
        issue(4'd8, 4'd3);
        wait_ready(seen, cyc);
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL abort_fresh_ready: ready=0 after %0d cycles, required 1", cyc);
        end else begin
            e = sb.pop_front();
            $display("txn %0d/%0d -> q=%0d r=%0d dbz=%0b", e.a, e.b,
                     bus.quotient, bus.remainder, bus.div_by_zero);
            n_cmp++;
            if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dbz}) begin
                n_bad++;
                $display("FAIL abort_fresh: q=%0d r=%0d dbz=%0b, required q=%0d r=%0d dbz=%0b",
                         bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
            end
        end
    endtask

    task automatic test_random();
        exp_t             e;
        bit               seen;
        int               cyc;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        for (int i = 0; i < 24; i++) begin
            a = WIDTH'($urandom);
            b = (i % 8 == 7) ? '0 : WIDTH'($urandom);
            sb.push_back(model(a, b));
            issue(a, b);
            wait_ready(seen, cyc);
            n_cmp++;
            if (!seen || cyc != ((b == '0) ? 0 : WIDTH)) begin
                n_bad++;
                $display("FAIL random_latency: %0d/%0d ready=%0b after %0d cycles", a, b, seen, cyc);
            end else begin
                e = sb.pop_front();
                $display("txn %0d/%0d -> q=%0d r=%0d dbz=%0b", e.a, e.b,
                         bus.quotient, bus.remainder, bus.div_by_zero);
                n_cmp++;
                if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dbz}) begin
                    n_bad++;
                    $display("FAIL random_result: %0d/%0d q=%0d r=%0d dbz=%0b, required q=%0d r=%0d dbz=%0b",
                             e.a, e.b, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

`ifdef DIVIDER_SIGNED_EN
    task automatic test_signed();
        exp_t e;
        exp_t tbl[3];
        bit   seen;
        int   cyc;
        tbl[0] = '{a: 4'b1001, b: 4'b0010, q: 4'b1101, r: 4'b1111, dbz: 1'b0};
        tbl[1] = '{a: 4'b1000, b: 4'b1111, q: 4'b1000, r: 4'b0000, dbz: 1'b0};
        tbl[2] = '{a: 4'b0111, b: 4'b1110, q: 4'b1101, r: 4'b0001, dbz: 1'b0};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(tbl[i]);
            issue(tbl[i].a, tbl[i].b);
            wait_ready(seen, cyc);
            n_cmp++;
            if (!seen || cyc != WIDTH) begin
                n_bad++;
                $display("FAIL signed_latency: ready=%0b after %0d cycles, required 1 after %0d",
                         seen, cyc, WIDTH);
            end else begin
                e = sb.pop_front();
                $display("txn %b/%b -> q=%b r=%b dbz=%0b", e.a, e.b,
                         bus.quotient, bus.remainder, bus.div_by_zero);
                n_cmp++;
                if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dbz}) begin
                    n_bad++;
                    $display("FAIL signed_result: q=%b r=%b dbz=%0b, required q=%b r=%b dbz=%0b",
                             bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
                end
            end
        end
    endtask
`endif

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_by_zero();
        test_start_while_busy();
        test_reset_abort();
        test_random();
`ifdef DIVIDER_SIGNED_EN
        test_signed();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
